// File: rtl/io_bus_dev.sv
// rtl/io_bus_dev.sv - IO-bus peripheral: LED register, 8-digit seven-segment scan,
// debounced button switch mailbox and a free-running cycle counter.
module io_bus_dev #(
  parameter int DEB_CYCLES  = 50000,
  parameter int SCAN_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_CYCLES - 1);

  localparam logic [7:0] ADDR_LED    = 8'h00;
  localparam logic [7:0] ADDR_SEG    = 8'h04;
  localparam logic [7:0] ADDR_STAT   = 8'h08;
  localparam logic [7:0] ADDR_SWDATA = 8'h0C;
  localparam logic [7:0] ADDR_CYCLE  = 8'h10;

  logic [15:0]   led_q, led_d;
  logic [31:0]   seg_word_q, seg_word_d;
  logic          valid_q, valid_d;
  logic [15:0]   sw_latched_q, sw_latched_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [15:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    led_d        = led_q;
    seg_word_d   = seg_word_q;
    valid_d      = valid_q;
    sw_latched_d = sw_latched_q;
    stable_d     = stable_q;
    deb_cnt_d    = deb_cnt_q;
    press_d      = 1'b0;
    idx_d        = idx_q;
    presc_d      = presc_q;
    sw_s1_d      = sw;
    sw_s2_d      = sw_s1_q;
    btn_s1_d     = btn;
    btn_s2_d     = btn_s1_q;
    cycle_d      = cycle_q + 32'd1;

    if (io_we) begin
      case (io_addr)
        ADDR_LED: led_d      = io_dout[15:0];
        ADDR_SEG: seg_word_d = io_dout;
        default:  ;
      endcase
    end

    // Only a disagreement that survives DEB_CYCLES straight edges moves the stable level.
    if (btn_s2_q == stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_cnt_d = '0;
      stable_d  = btn_s2_q;
      press_d   = btn_s2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    // A capture beats a simultaneous SWDATA read-clear.
    if (press_q) begin
      valid_d      = 1'b1;
      sw_latched_d = sw_s2_q;
    end else if (io_rd && (io_addr == ADDR_SWDATA)) begin
      valid_d = 1'b0;
    end

    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q        <= '0;
      seg_word_q   <= '0;
      valid_q      <= 1'b0;
      sw_latched_q <= '0;
      cycle_q      <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      deb_cnt_q    <= '0;
      stable_q     <= 1'b0;
      press_q      <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
    end else begin
      led_q        <= led_d;
      seg_word_q   <= seg_word_d;
      valid_q      <= valid_d;
      sw_latched_q <= sw_latched_d;
      cycle_q      <= cycle_d;
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      deb_cnt_q    <= deb_cnt_d;
      stable_q     <= stable_d;
      press_q      <= press_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
    end
  end

  always_comb begin
    case (io_addr)
      ADDR_LED:    io_din = {16'b0, led_q};
      ADDR_SEG:    io_din = seg_word_q;
      ADDR_STAT:   io_din = {31'b0, valid_q};
      ADDR_SWDATA: io_din = {16'b0, sw_latched_q};
      ADDR_CYCLE:  io_din = cycle_q;
      default:     io_din = 32'b0;
    endcase
  end

  assign led = led_q;
  assign an  = ~(8'b1 << idx_q);
  assign seg = hex7(seg_word_q[{idx_q, 2'b00} +: 4]);

endmodule

// File: tb/tb_io_bus_dev.sv
// tb/tb_io_bus_dev.sv - scoreboard bench for io_bus_dev against a cycle-level reference model.
module tb_io_bus_dev;
  localparam int DEB  = 4;
  localparam int SCAN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        probe;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] e;
  } rd_t;
  rd_t         rd_q[$];
  logic [30:0] pr_q[$];

  io_bus_dev #(.DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn), .led(led), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_led, m_swl, m_sw1, m_sw2;
  logic [31:0] m_seg, m_cycle;
  logic        m_valid, m_b1, m_b2, m_stable, m_press;
  int          m_run;
  logic [6:0]  dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    m_led = 0; m_swl = 0; m_sw1 = 0; m_sw2 = 0; m_seg = 0; m_cycle = 0;
    m_valid = 0; m_b1 = 0; m_b2 = 0; m_stable = 0; m_press = 0; m_run = 0;
  endtask

  task automatic model_step();
    if (io_we && io_addr == 8'h00) m_led = io_dout[15:0];
    if (io_we && io_addr == 8'h04) m_seg = io_dout;
    if (m_press) begin
      m_valid = 1; m_swl = m_sw2;
    end else if (io_rd && io_addr == 8'h0C) begin
      m_valid = 0;
    end
    m_press = 0;
    if (m_b2 == m_stable) m_run = 0;
    else begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_b2; m_run = 0; m_press = m_stable;
      end
    end
    m_b2 = m_b1; m_b1 = btn; m_sw2 = m_sw1; m_sw1 = sw;
    m_cycle = m_cycle + 1;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return {16'b0, m_led};
      8'h04: return m_seg;
      8'h08: return {31'b0, m_valid};
      8'h0C: return {16'b0, m_swl};
      8'h10: return m_cycle;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [30:0] model_probe();
    int unsigned digit;
    logic [3:0] nib;
    logic [7:0] an_e;
    digit = (m_cycle / SCAN) % 8;
    nib   = m_seg[digit*4 +: 4];
    an_e  = ~(8'b1 << digit);
    return {an_e, dec[nib], m_led};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic drive(input logic we, input logic rd, input logic [7:0] a,
                       input logic [31:0] d, input logic pr);
    rd_t r;
    io_we = we; io_rd = rd; io_addr = a; io_dout = d; probe = pr;
    if (rd) begin
      r.a = a; r.e = model_read(a);
      rd_q.push_back(r);
    end
    if (pr) pr_q.push_back(model_probe());
  endtask

  task automatic cyc(input logic we, input logic rd, input logic [7:0] a,
                     input logic [31:0] d, input logic pr);
    tick();
    drive(we, rd, a, d, pr);
  endtask

  task automatic do_reset(input int n);
    tick();
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 8'h08, 32'h0, 1'b1);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 8'(4 * (i % 5)), 32'h0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
  endtask

  // Monitor: compares whenever a read strobe or a display probe is presented.
  initial begin
    rd_t r;
    logic [30:0] p;
    forever begin
      @(negedge clk);
      if (io_rd) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_underflow: read with no expected value, io_din=%08h", io_din);
        end else begin
          r = rd_q.pop_front();
          if (io_din !== r.e) begin
            errors++;
            $display("FAIL rd@%02h: got %08h expected %08h (t=%0t)", r.a, io_din, r.e, $time);
          end
        end
      end
      if (probe) begin
        checks++;
        if (pr_q.size() == 0) begin
          errors++;
          $display("FAIL probe_underflow: got an=%02h seg=%02h led=%04h", an, seg, led);
        end else begin
          p = pr_q.pop_front();
          if ({an, seg, led} !== p) begin
            errors++;
            $display("FAIL probe: got an=%02h seg=%02h led=%04h expected an=%02h seg=%02h led=%04h (t=%0t)",
                     an, seg, led, p[30:23], p[22:16], p[15:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] addrs [6];
    int hold;
    bit found;
    rst = 1'b1; io_we = 0; io_rd = 0; io_addr = 0; io_dout = 0; sw = 0; btn = 0; probe = 0;
    model_reset();
    do_reset(3);

    // LED write/readback and unmapped write
    cyc(1'b1, 1'b0, 8'h00, 32'hDEADBEEF, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 8'h44, 32'h12345678, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(i * 4 + (i == 5 ? 8'h30 : 8'h0)), 32'h0, 1'b0);

    // Mid-run reset
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    do_reset(2);

    // Display scan across a full refresh and wrap
    cyc(1'b1, 1'b0, 8'h04, 32'h76543210, 1'b1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

    // Counter after release
    do_reset(1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h10, 32'h0, 1'b0);

    // Button capture latency
    tick();
    rst = 1'b1; model_reset();
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    tick();
    sw = 16'hA5A5; btn = 1'b1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 8'h0C, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    btn = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);

    // Glitch rejection then a single accepted short press
    btn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    btn = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    sw = 16'h5A5A; btn = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    btn = 1'b0;
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 8'h0C, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);

    // Collision: SWDATA read on the capture edge
    sw = 16'h00FF; btn = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
      found = m_valid;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL setup_capture: timed out waiting for capture"); end
    btn = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    sw = 16'h1234; btn = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (m_press) begin
        drive(1'b0, 1'b1, 8'h0C, 32'h0, 1'b0);
        found = 1;
      end else begin
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL collision_wait: timed out waiting for press edge"); end
    cyc(1'b0, 1'b1, 8'h08, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 8'h0C, 32'h0, 1'b0);
    btn = 1'b0;

    // Randomized traffic
    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08;
    addrs[3] = 8'h0C; addrs[4] = 8'h10;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      int op;
      if (hold == 0) begin
        btn = 1'($urandom);
        hold = $urandom_range(1, 9);
        if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      end
      hold--;
      addrs[5] = 8'($urandom);
      a = addrs[$urandom_range(0, 5)];
      op = $urandom_range(0, 3);
      cyc(op == 0, op == 1 || op == 2, a, $urandom, $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    checks++;
    if (rd_q.size() != 0 || pr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d probes left unchecked", rd_q.size(), pr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
